// File: rtl/fb_write_arbiter_pkg.sv
// Shared types and constants for the frame-buffer write arbiter.
// Holds the write-record layout, the grant encoding and the fill-engine state encoding.
package fb_pkg;

    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 16;
    localparam int FB_DEPTH = 76800;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fb_wr_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CAM  = 2'd1,
        GNT_CLR  = 2'd2,
        GNT_SPR  = 2'd3
    } fb_gnt_e;

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_RUN  = 2'd1,
        CLR_DONE = 2'd2
    } fb_clr_e;

endpackage

// File: rtl/fb_write_arbiter_cam_fifo.sv
// Camera skid FIFO: absorbs pixels while another source owns the write port.
// Read data is the head entry, presented combinationally (first-word fall-through).
module fb_cam_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_push,
    input  fb_wr_t i_din,
    input  logic   i_pop,
    output fb_wr_t o_dout,
    output logic   o_full,
    output logic   o_empty
);

    localparam int PW = $clog2(DEPTH);

    fb_wr_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_dout  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Sole owner of the frame-buffer write port: arbitrates camera, sprite and fill writes,
// with one registered write per cycle and out-of-range writes suppressed.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = fb_pkg::ADDR_W,
    parameter int DATA_W     = fb_pkg::DATA_W,
    parameter int FB_DEPTH   = fb_pkg::FB_DEPTH,
    parameter int CAM_FIFO   = 4,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_valid,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_data,
    // Sprite handshake: a write transfers on a cycle where spr_valid && spr_ready;
    // spr_ready is a same-cycle grant and only rises while spr_valid is high.
    input  logic              spr_valid,
    output logic              spr_ready,
    input  logic [ADDR_W-1:0] spr_addr,
    input  logic [DATA_W-1:0] spr_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic [DATA_W-1:0] fb_wdata,
    output logic              cam_overflow,
    output logic              oob_err,
    output logic [1:0]        o_dbg_clr_state
);

    localparam logic [1:0] S_IDLE = CLR_IDLE;
    localparam logic [1:0] S_RUN  = CLR_RUN;
    localparam logic [1:0] S_DONE = CLR_DONE;

    localparam int                SW       = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]     LP_SMAX  = SW'(STARVE_MAX);
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(FB_DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(FB_DEPTH - 1);

    logic [1:0]        r_clr_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [DATA_W-1:0] r_clr_color;
    logic [SW-1:0]     r_starve;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_oob;
    logic              r_overflow;

    fb_wr_t            w_cam_in;
    fb_wr_t            w_fifo_dout;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_fifo_pop;
    logic              w_cam_drop;
    fb_gnt_e           w_gnt;
    logic              w_any_gnt;
    logic              w_clr_gnt;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_in_range;

    assign w_cam_in.addr = cam_addr;
    assign w_cam_in.data = cam_data;

    fb_cam_fifo #(
        .DEPTH (CAM_FIFO)
    ) u_cam_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (cam_valid),
        .i_din   (w_cam_in),
        .i_pop   (w_fifo_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // A starved sprite outranks everything; otherwise camera, then fill, then sprite.
    always_comb begin
        w_gnt = GNT_NONE;
        if (spr_valid && (r_starve == LP_SMAX)) begin
            w_gnt = GNT_SPR;
        end else if (!w_fifo_empty) begin
            w_gnt = GNT_CAM;
        end else if (r_clr_state == S_RUN) begin
            w_gnt = GNT_CLR;
        end else if (spr_valid) begin
            w_gnt = GNT_SPR;
        end
    end

    always_comb begin
        w_sel_addr = w_fifo_dout.addr;
        w_sel_data = w_fifo_dout.data;
        case (w_gnt)
            GNT_CLR: begin
                w_sel_addr = r_clr_addr;
                w_sel_data = r_clr_color;
            end
            GNT_SPR: begin
                w_sel_addr = spr_addr;
                w_sel_data = spr_data;
            end
            default: begin
                w_sel_addr = w_fifo_dout.addr;
                w_sel_data = w_fifo_dout.data;
            end
        endcase
    end

    assign w_any_gnt  = (w_gnt != GNT_NONE);
    assign w_clr_gnt  = (w_gnt == GNT_CLR);
    assign w_fifo_pop = (w_gnt == GNT_CAM);
    assign w_in_range = ({1'b0, w_sel_addr} < LP_DEPTH);
    assign w_cam_drop = cam_valid && w_fifo_full && !w_fifo_pop;

    assign spr_ready = (w_gnt == GNT_SPR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else if (spr_valid && !spr_ready) begin
            r_starve <= (r_starve == LP_SMAX) ? r_starve : r_starve + 1'b1;
        end else begin
            r_starve <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_state <= S_IDLE;
            r_clr_addr  <= '0;
            r_clr_color <= '0;
        end else begin
            case (r_clr_state)
                S_IDLE: begin
                    if (clr_start) begin
                        r_clr_state <= S_RUN;
                        r_clr_addr  <= '0;
                        r_clr_color <= clr_color;
                    end
                end
                S_RUN: begin
                    if (w_clr_gnt) begin
                        if (r_clr_addr == LP_LAST) begin
                            r_clr_state <= S_DONE;
                        end else begin
                            r_clr_addr <= r_clr_addr + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_clr_state <= S_IDLE;
                end
                default: begin
                    r_clr_state <= S_IDLE;
                end
            endcase
        end
    end

    // Out-of-range grants still consume the request but never reach the frame buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_oob      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_we       <= w_any_gnt && w_in_range;
            r_oob      <= w_any_gnt && !w_in_range;
            r_overflow <= r_overflow || w_cam_drop;
            if (w_any_gnt && w_in_range) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign fb_we           = r_we;
    assign fb_waddr        = r_waddr;
    assign fb_wdata        = r_wdata;
    assign oob_err         = r_oob;
    assign cam_overflow    = r_overflow;
    assign clr_busy        = (r_clr_state == S_RUN);
    assign clr_done        = (r_clr_state == S_DONE);
    assign o_dbg_clr_state = r_clr_state;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: expected camera/sprite writes are queued at issue time,
// fill writes are checked as an ascending address stream, and a negedge monitor compares.
`timescale 1ns/1ps
module tb_fb_write_arbiter;

    localparam int          ADDR_W     = 17;
    localparam int          DATA_W     = 16;
    localparam int          FB_DEPTH   = 76800;
    localparam logic [15:0] FILL_COLOR = 16'h001F;

    logic              clk = 1'b0;
    logic              reset;
    logic              cam_valid;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_data;
    logic              spr_valid;
    logic              spr_ready;
    logic [ADDR_W-1:0] spr_addr;
    logic [DATA_W-1:0] spr_data;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_waddr;
    logic [DATA_W-1:0] fb_wdata;
    logic              cam_overflow;
    logic              oob_err;
    logic [1:0]        dbg_clr_state;

    logic [ADDR_W+DATA_W-1:0] exp_cam_q[$];
    logic [ADDR_W+DATA_W-1:0] exp_spr_q[$];

    int compared     = 0;
    int mismatched   = 0;
    int fill_starts  = 0;
    int seen_starts  = 0;
    int next_fill    = 0;
    int clr_done_cnt = 0;
    int oob_cnt      = 0;

    fb_write_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .cam_valid       (cam_valid),
        .cam_addr        (cam_addr),
        .cam_data        (cam_data),
        .spr_valid       (spr_valid),
        .spr_ready       (spr_ready),
        .spr_addr        (spr_addr),
        .spr_data        (spr_data),
        .clr_start       (clr_start),
        .clr_color       (clr_color),
        .clr_busy        (clr_busy),
        .clr_done        (clr_done),
        .fb_we           (fb_we),
        .fb_waddr        (fb_waddr),
        .fb_wdata        (fb_wdata),
        .cam_overflow    (cam_overflow),
        .oob_err         (oob_err),
        .o_dbg_clr_state (dbg_clr_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic spr_send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            output int waited);
        spr_valid = 1'b1;
        spr_addr  = a;
        spr_data  = d;
        waited    = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (spr_ready !== 1'b1 && waited < 100);
        @(posedge clk);
        #1;
        spr_valid = 1'b0;
    endtask

    task automatic start_fill(input string tag);
        fill_starts++;
        clr_color = FILL_COLOR;
        clr_start = 1'b1;
        @(negedge clk);
        chk({tag, "_busy_not_yet"}, clr_busy, 0);
        cyc();
        clr_start = 1'b0;
        @(negedge clk);
        chk({tag, "_busy_rise"}, clr_busy, 1);
        chk({tag, "_state_run"}, dbg_clr_state, 1);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (fill_starts != seen_starts) begin
                seen_starts = fill_starts;
                next_fill   = 0;
            end
            if (clr_done === 1'b1) clr_done_cnt++;
            if (oob_err === 1'b1) oob_cnt++;
            if (fb_we === 1'b1) begin
                if (fb_wdata == FILL_COLOR) begin
                    chk("fill_addr", fb_waddr, next_fill);
                    next_fill++;
                end else if (fb_wdata[15]) begin
                    if (exp_cam_q.size() == 0) begin
                        chk("cam_unexpected", {fb_waddr, fb_wdata}, 64'hDEAD_0000_0000);
                    end else begin
                        chk("cam_write", {fb_waddr, fb_wdata}, exp_cam_q.pop_front());
                    end
                end else begin
                    if (exp_spr_q.size() == 0) begin
                        chk("spr_unexpected", {fb_waddr, fb_wdata}, 64'hDEAD_0000_0000);
                    end else begin
                        chk("spr_write", {fb_waddr, fb_wdata}, exp_spr_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int cnt;
        reset     = 1'b1;
        cam_valid = 1'b0;
        cam_addr  = '0;
        cam_data  = '0;
        spr_valid = 1'b0;
        spr_addr  = '0;
        spr_data  = '0;
        clr_start = 1'b0;
        clr_color = '0;
        repeat (3) cyc();
        reset = 1'b0;

        // Reset then idle: every output low for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs",
                {fb_we, fb_waddr, fb_wdata, spr_ready, clr_busy, clr_done, cam_overflow, oob_err},
                0);
        end
        cyc();

        // Camera burst of 8 pixels; first write lands two cycles after its strobe.
        for (int i = 0; i < 8; i++) begin
            cam_valid = 1'b1;
            cam_addr  = ADDR_W'(i);
            cam_data  = 16'hF800;
            exp_cam_q.push_back({ADDR_W'(i), 16'hF800});
            if (i == 1) chk("cam_lat_not_early", fb_we, 0);
            if (i == 2) chk("cam_lat_first", {fb_we, fb_waddr}, {1'b1, 17'd0});
            cyc();
        end
        cam_valid = 1'b0;
        repeat (5) cyc();
        chk("cam_burst_drained", exp_cam_q.size(), 0);
        chk("cam_no_overflow", cam_overflow, 0);

        // Idle sprite grant is immediate; out-of-range sprite is consumed and flagged.
        exp_spr_q.push_back({17'd100, 16'h07E0});
        spr_send(17'd100, 16'h07E0, w);
        chk("spr_idle_wait", w, 1);
        spr_send(17'd76800, 16'h4ABC, w);
        chk("oob_ready_wait", w, 1);
        chk("oob_pulse", {oob_err, fb_we}, 2'b10);
        cyc();
        chk("oob_pulse_end", oob_err, 0);
        chk("spr_drained", exp_spr_q.size(), 0);

        // Full-frame fill, with a second clr_start mid-fill that must be ignored.
        start_fill("fill1");
        repeat (1000) cyc();
        clr_start = 1'b1;
        clr_color = 16'h7777;
        cyc();
        clr_start = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (clr_done !== 1'b1 && cnt < 80000);
        chk("fill1_done_seen", clr_done, 1);
        chk("fill1_busy_at_done", clr_busy, 0);
        @(negedge clk);
        chk("fill1_done_pulse", clr_done, 0);
        chk("fill1_write_count", next_fill, FB_DEPTH);
        chk("fill1_state_idle", dbg_clr_state, 0);
        chk("fill1_done_count", clr_done_cnt, 1);
        cyc();

        // Fill with sprite held valid: sprite granted on every 16th cycle.
        start_fill("fill2");
        cyc();
        for (int k = 0; k < 3; k++) begin
            exp_spr_q.push_back({ADDR_W'(3000 + k), 16'h4100 | 16'(k)});
            spr_send(ADDR_W'(3000 + k), 16'h4100 | 16'(k), w);
            chk("fill2_spr_wait", w, 16);
        end
        // Camera pixel injected mid-fill preempts the next fill address.
        cam_valid = 1'b1;
        cam_addr  = 17'd500;
        cam_data  = 16'hABCD;
        exp_cam_q.push_back({17'd500, 16'hABCD});
        cyc();
        cam_valid = 1'b0;
        cyc();
        chk("fill2_cam_preempt", {fb_we, fb_waddr, fb_wdata}, {1'b1, 17'd500, 16'hABCD});

        // Camera every cycle while sprite takes forced grants: 4th forced grant drops pixel 63.
        fork
            begin
                for (int i = 0; i < 70; i++) begin
                    cam_valid = 1'b1;
                    cam_addr  = ADDR_W'(1000 + i);
                    cam_data  = 16'hC000 | 16'(i);
                    if (i != 63) exp_cam_q.push_back({ADDR_W'(1000 + i), 16'hC000 | 16'(i)});
                    if (i == 63) chk("ovf_before_drop", cam_overflow, 0);
                    if (i == 64) chk("ovf_after_drop", cam_overflow, 1);
                    cyc();
                end
                cam_valid = 1'b0;
            end
            begin
                int ws;
                for (int k = 0; k < 4; k++) begin
                    exp_spr_q.push_back({ADDR_W'(2000 + k), 16'h4200 | 16'(k)});
                    spr_send(ADDR_W'(2000 + k), 16'h4200 | 16'(k), ws);
                    chk("ovf_spr_wait", ws, 16);
                end
            end
        join
        repeat (10) cyc();
        chk("ovf_sticky", cam_overflow, 1);
        chk("ovf_cam_drained", exp_cam_q.size(), 0);
        chk("ovf_spr_drained", exp_spr_q.size(), 0);
        chk("fill2_still_busy", clr_busy, 1);

        // Reset mid-fill with a pixel arriving in the reset cycle: nothing survives.
        reset     = 1'b1;
        cam_valid = 1'b1;
        cam_addr  = 17'd1500;
        cam_data  = 16'hC5A5;
        cyc();
        reset     = 1'b0;
        cam_valid = 1'b0;
        @(negedge clk);
        chk("rst_busy", clr_busy, 0);
        chk("rst_done", clr_done, 0);
        chk("rst_we", fb_we, 0);
        chk("rst_overflow", cam_overflow, 0);
        chk("rst_state", dbg_clr_state, 0);
        repeat (10) cyc();
        chk("rst_no_done_pulse", clr_done_cnt, 1);
        chk("oob_total", oob_cnt, 1);
        chk("final_cam_q", exp_cam_q.size(), 0);
        chk("final_spr_q", exp_spr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
